i2d_if: RTL and testbench

- Instruction fetch stage of the i2d pipeline. It owns the fetch PC and issues word fetches to instruction memory over a req/ack handshake.
- Fetched words are buffered in a 2-entry prefetch FIFO and presented to i2d_id on if_ins/if_pc/if_dis.
- It honours ID stall and redirects on branch, discarding wrong-path and in-flight fetches.

---
 rtl/i2d_if_if.sv | 11 +
 rtl/i2d_if.sv | 173 +++++++++++++++++
 tb/tb_i2d_if.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2d_if_if.sv
// Instruction-memory fetch bus of the i2d pipeline: one word per req/ack handshake.
interface i2d_if_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        err;

    modport master (output req, output addr, input ack, input data, input err);
    modport slave  (input req, input addr, output ack, output data, output err);
endinterface

// File: rtl/i2d_if.sv
// i2d instruction fetch stage: owns the fetch PC, buffers words in a 2-entry
// prefetch FIFO and presents them to ID, honouring stall and branch redirects.
module i2d_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    i2d_if_if.master        imem,
    input  logic            id_stall,
    input  logic            branch,
    input  logic [31:0]     branch_pc,
    output logic [31:0]     if_ins,
    output logic [31:0]     if_pc,
    output logic            if_dis,
    output logic            if_err
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        WAIT,
        DROP
    } state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        err;
    } slot_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic [31:0] branch_tgt;

    slot_t       fifo_mem [DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        push;
    logic        pop;
    slot_t       head;

    assign next_pc    = fetch_pc + 32'd4;
    assign branch_tgt = branch_pc & 32'hFFFF_FFFC;
    assign head       = fifo_mem[rd_ptr];

    // Words acked while draining a wrong-path fetch (DROP) never enter the FIFO.
    assign push = imem.req && imem.ack && !branch && (state == FETCH);
    assign pop  = !branch && !id_stall && (count != 2'd0);

    // NOTE: every variable driven in always_comb gets a value on every path, or a latch is inferred.
    always_comb begin
        count_next = count;
        if (branch) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= START;
            fetch_pc  <= RESET_PC;
            imem.req  <= 1'b0;
            imem.addr <= RESET_PC;
        end else if (branch) begin
            fetch_pc <= branch_tgt;
            if ((state == FETCH || state == DROP) && !imem.ack) begin
                // The outstanding fetch must still complete at its own address.
                state <= DROP;
            end else begin
                state     <= FETCH;
                imem.req  <= 1'b1;
                imem.addr <= branch_tgt;
            end
        end else begin
            case (state)
                START: begin
                    state     <= FETCH;
                    imem.req  <= 1'b1;
                    imem.addr <= fetch_pc;
                end
                FETCH: begin
                    if (imem.ack) begin
                        fetch_pc  <= next_pc;
                        imem.addr <= next_pc;
                        if (count_next == FULL) begin
                            state    <= WAIT;
                            imem.req <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (pop) begin
                        state    <= FETCH;
                        imem.req <= 1'b1;
                        imem.addr <= fetch_pc;
                    end
                end
                DROP: begin
                    if (imem.ack) begin
                        state     <= FETCH;
                        imem.addr <= fetch_pc;
                    end
                end
                default: begin
                    state    <= START;
                    imem.req <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{ins: imem.data, pc: imem.addr, err: imem.err};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (branch) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Output slot: a branch always bubbles, even over a stall; if_pc keeps its last value on bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_ins <= 32'd0;
            if_pc  <= 32'd0;
            if_dis <= 1'b1;
            if_err <= 1'b0;
        end else if (branch) begin
            if_ins <= 32'd0;
            if_dis <= 1'b1;
            if_err <= 1'b0;
        end else if (!id_stall) begin
            if (count != 2'd0) begin
                if_ins <= head.ins;
                if_pc  <= head.pc;
                if_dis <= 1'b0;
                if_err <= head.err;
            end else begin
                if_ins <= 32'd0;
                if_dis <= 1'b1;
                if_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2d_if.sv
// Self-checking bench for i2d_if: a memory model feeds a scoreboard of expected
// slots, which is compared against ID-side outputs on every falling edge.
module tb_i2d_if;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        branch;
    logic [31:0] branch_pc;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_dis;
    logic        if_err;

    i2d_if_if imem ();

    i2d_if #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem),
        .id_stall  (id_stall),
        .branch    (branch),
        .branch_pc (branch_pc),
        .if_ins    (if_ins),
        .if_pc     (if_pc),
        .if_dis    (if_dis),
        .if_err    (if_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];

    // Memory model controls.
    logic        ack_en;
    logic        force_en;
    logic [31:0] force_data;
    logic [31:0] err_addr;
    bit          drop_pending;

    // What happened at the edge just simulated, plus the model's view of the output slot.
    bit          br_edge;
    bit          st_edge;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [31:0] last_ins;
    logic [31:0] last_pc;
    logic        last_dis;
    logic        last_err;

    // Called at a falling edge: checks bus rules, then answers the request for the coming edge.
    task automatic mem_drive();
        logic [31:0] a;
        a = imem.addr;
        if (prev_req && !prev_ack && imem.req) begin
            checks++;
            if (imem.addr !== prev_addr)
                $display("FAIL addr_stable: imem_addr=%h required %h", imem.addr, prev_addr);
            if (imem.addr !== prev_addr) errors++;
        end
        if (imem.req) begin
            checks++;
            if (dut.count === 2'd2 || imem.addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL req_legal: req with count=%0d addr=%h, required count<2 and aligned addr",
                         dut.count, imem.addr);
            end
        end
        imem.ack  = ack_en && imem.req;
        imem.data = force_en ? force_data : ~a;
        imem.err  = (a == err_addr);
        if (imem.req && imem.ack) begin
            if (!branch && !drop_pending) sb.push_back('{pc: a, ins: imem.data, err: imem.err});
            drop_pending = 1'b0;
        end else if (imem.req && branch) begin
            drop_pending = 1'b1;
        end
        if (branch) sb.delete();
        prev_req  = imem.req;
        prev_ack  = imem.ack;
        prev_addr = a;
    endtask

    task automatic monitor();
        exp_t e;
        checks++;
        if (br_edge) begin
            if (if_dis !== 1'b1 || if_ins !== 32'd0 || if_err !== 1'b0) begin
                errors++;
                $display("FAIL branch_bubble: dis=%b ins=%h err=%b required 1/0/0", if_dis, if_ins, if_err);
            end
            last_dis = 1'b1; last_ins = 32'd0; last_err = 1'b0;
        end else if (st_edge) begin
            if ({if_ins, if_pc, if_dis, if_err} !== {last_ins, last_pc, last_dis, last_err}) begin
                errors++;
                $display("FAIL stall_hold: ins=%h pc=%h dis=%b err=%b required %h %h %b %b",
                         if_ins, if_pc, if_dis, if_err, last_ins, last_pc, last_dis, last_err);
            end
        end else if (if_dis === 1'b0) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_slot: pc=%h ins=%h with no word expected", if_pc, if_ins);
            end else begin
                e = sb.pop_front();
                if (if_pc !== e.pc || if_ins !== e.ins || if_err !== e.err) begin
                    errors++;
                    $display("FAIL slot: pc=%h ins=%h err=%b required %h %h %b",
                             if_pc, if_ins, if_err, e.pc, e.ins, e.err);
                end
                last_dis = 1'b0; last_ins = e.ins; last_pc = e.pc; last_err = e.err;
            end
        end else begin
            if (if_dis !== 1'b1 || if_ins !== 32'd0 || if_err !== 1'b0 || if_pc !== last_pc) begin
                errors++;
                $display("FAIL bubble: dis=%b ins=%h err=%b pc=%h required 1 0 0 %h",
                         if_dis, if_ins, if_err, if_pc, last_pc);
            end
            last_dis = 1'b1; last_ins = 32'd0; last_err = 1'b0;
        end
    endtask

    task automatic cycle();
        mem_drive();
        br_edge = branch;
        st_edge = id_stall;
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic init_model();
        branch = 1'b0; branch_pc = 32'd0; id_stall = 1'b0;
        ack_en = 1'b0; force_en = 1'b0; force_data = 32'd0; err_addr = 32'h1;
        imem.ack = 1'b0; imem.data = 32'd0; imem.err = 1'b0;
        sb.delete(); drop_pending = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
        last_ins = 32'd0; last_pc = 32'd0; last_dis = 1'b1; last_err = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        init_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (imem.req !== 1'b0 || imem.addr !== 32'd0) begin
            errors++;
            $display("FAIL %s_bus: req=%b addr=%h required 0 00000000", tag, imem.req, imem.addr);
        end
        checks++;
        if (if_ins !== 32'd0 || if_pc !== 32'd0 || if_dis !== 1'b1 || if_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_out: ins=%h pc=%h dis=%b err=%b required 0 0 1 0", tag, if_ins, if_pc, if_dis, if_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        init_model();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
    endtask

    task automatic test_throughput();
        ack_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (imem.req !== 1'b1 || imem.addr !== 32'(4 * (k - 1))) begin
                errors++;
                $display("FAIL tput_addr edge %0d: req=%b addr=%h required 1 %h", k, imem.req, imem.addr, 32'(4 * (k - 1)));
            end
            checks++;
            if (if_dis !== (k < 3 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL tput_dis edge %0d: if_dis=%b required %b", k, if_dis, (k < 3 ? 1'b1 : 1'b0));
            end
            if (k >= 3) begin
                checks++;
                if (if_pc !== 32'(4 * (k - 3))) begin
                    errors++;
                    $display("FAIL tput_pc edge %0d: if_pc=%h required %h", k, if_pc, 32'(4 * (k - 3)));
                end
            end
        end
    endtask

    task automatic test_stall();
        id_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (imem.req !== 1'b0 || if_dis !== 1'b0) begin
                errors++;
                $display("FAIL stall_wait %0d: req=%b dis=%b required 0 0", k, imem.req, if_dis);
            end
        end
        id_stall = 1'b0;
        cycle();
        checks++;
        if (imem.req !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: req=%b required 1", imem.req);
        end
        repeat (6) cycle();
    endtask

    task automatic test_branch_pending();
        reset_dut();
        cycle();
        cycle();
        branch = 1'b1; branch_pc = 32'h100;
        cycle();
        branch = 1'b0;
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0 || if_dis !== 1'b1) begin
            errors++;
            $display("FAIL drop_hold: req=%b addr=%h dis=%b required 1 00000000 1", imem.req, imem.addr, if_dis);
        end
        cycle();
        ack_en = 1'b1; force_en = 1'b1; force_data = 32'hDEAD;
        cycle();
        force_en = 1'b0;
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin
            errors++;
            $display("FAIL drop_redirect: req=%b addr=%h required 1 00000100", imem.req, imem.addr);
        end
        cycle();
        checks++;
        if (if_dis !== 1'b1) begin
            errors++;
            $display("FAIL drop_gap: if_dis=%b required 1", if_dis);
        end
        cycle();
        checks++;
        if (if_dis !== 1'b0 || if_pc !== 32'h100 || if_ins !== ~32'h100) begin
            errors++;
            $display("FAIL drop_target: dis=%b pc=%h ins=%h required 0 00000100 %h", if_dis, if_pc, if_ins, ~32'h100);
        end
        repeat (3) cycle();
    endtask

    task automatic test_branch_ack();
        reset_dut();
        ack_en = 1'b1;
        repeat (5) cycle();
        branch = 1'b1; branch_pc = 32'h203;
        cycle();
        branch = 1'b0;
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin
            errors++;
            $display("FAIL bra_addr: req=%b addr=%h required 1 00000200", imem.req, imem.addr);
        end
        cycle();
        checks++;
        if (if_dis !== 1'b1) begin
            errors++;
            $display("FAIL bra_gap: if_dis=%b required 1", if_dis);
        end
        cycle();
        checks++;
        if (if_dis !== 1'b0 || if_pc !== 32'h200) begin
            errors++;
            $display("FAIL bra_target: dis=%b pc=%h required 0 00000200", if_dis, if_pc);
        end
        repeat (3) cycle();
    endtask

    task automatic test_branch_stall();
        reset_dut();
        ack_en = 1'b1;
        repeat (4) cycle();
        id_stall = 1'b1;
        repeat (2) cycle();
        branch = 1'b1; branch_pc = 32'h400;
        cycle();
        branch = 1'b0;
        checks++;
        if (if_dis !== 1'b1 || if_ins !== 32'd0) begin
            errors++;
            $display("FAIL brs_bubble: dis=%b ins=%h required 1 00000000", if_dis, if_ins);
        end
        repeat (3) cycle();
        id_stall = 1'b0;
        cycle();
        checks++;
        if (if_dis !== 1'b0 || if_pc !== 32'h400) begin
            errors++;
            $display("FAIL brs_target: dis=%b pc=%h required 0 00000400", if_dis, if_pc);
        end
        repeat (4) cycle();
    endtask

    task automatic test_err_and_reset();
        reset_dut();
        ack_en = 1'b1; err_addr = 32'h8;
        repeat (5) cycle();
        checks++;
        if (if_dis !== 1'b0 || if_pc !== 32'h8 || if_err !== 1'b1) begin
            errors++;
            $display("FAIL err_slot: dis=%b pc=%h err=%b required 0 00000008 1", if_dis, if_pc, if_err);
        end
        cycle();
        checks++;
        if (if_pc !== 32'hC || if_err !== 1'b0) begin
            errors++;
            $display("FAIL err_next: pc=%h err=%b required 0000000c 0", if_pc, if_err);
        end
        rst = 1'b0;
        imem.ack = 1'b0;
        #1;
        check_reset_values("midrst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_throughput();
        test_stall();
        test_branch_pending();
        test_branch_ack();
        test_branch_stall();
        test_err_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
